// File: rtl/clock_generator_multi.sv
// Multi-channel programmable clock divider: per-channel one-cycle tick and
// near-50 % square wave, with global enable, phase sync and checked writes.
module clock_generator_multi #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = CLK_FREQ_HZ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic              wr_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] wrap;
    logic              wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < NUM_CH_V) && (wr_div >= CNT_W'(2));

    always_comb begin
        hit  = '0;
        wrap = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            hit[i]  = wr_ok && (wr_ch == CH_W'(i));
            wrap[i] = (cnt_q[i] == div_q[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= '0;
            end
            tick    <= '0;
            clk_out <= '0;
            wr_err  <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (hit[i]) begin
                    div_q[i] <= wr_div;
                end
                // Restart (sync or fresh divide) overrides any wrap on this edge.
                if (sync || hit[i]) begin
                    cnt_q[i]   <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= 1'b0;
                end else if (en) begin
                    cnt_q[i]   <= wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
                    tick[i]    <= wrap[i];
                    clk_out[i] <= (cnt_q[i] >= (div_q[i] >> 1));
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_generator_multi.sv
// Directed bench for clock_generator_multi: expected tick/clk_out derived
// from the edge count since the last channel alignment.
module tb_clock_generator_multi;

    logic        clk = 1'b0;
    logic        reset, en, sync;
    logic        wr_en, wr_en3;
    logic [1:0]  wr_ch, wr_ch3;
    logic [31:0] wr_div, wr_div3;
    logic        wr_err, wr_err3;
    logic [3:0]  tick, clk_out;
    logic [2:0]  tick3, clk_out3;

    int checks = 0;
    int errors = 0;
    int exp_div[4];
    int div10[4];
    logic [3:0] frozen;

    always #5 clk = ~clk;

    clock_generator_multi #(.NUM_CH(4), .CH_W(2), .CNT_W(32), .DEFAULT_DIV(10)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .wr_err(wr_err), .tick(tick), .clk_out(clk_out));

    clock_generator_multi #(.NUM_CH(3), .CH_W(2), .CNT_W(32), .DEFAULT_DIV(10)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_div(wr_div3),
        .wr_err(wr_err3), .tick(tick3), .clk_out(clk_out3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = enabled edges since all channels were at cnt=0
    function automatic logic [3:0] exp_tick(input int k, input int d[4]);
        logic [3:0] v = '0;
        for (int c = 0; c < 4; c++) v[c] = (k % d[c] == 0);
        return v;
    endfunction

    function automatic logic [3:0] exp_clk(input int k, input int d[4]);
        logic [3:0] v = '0;
        for (int c = 0; c < 4; c++) v[c] = ((k - 1) % d[c] >= d[c] / 2);
        return v;
    endfunction

    initial begin
        logic [3:0] et, ec;
        reset = 1'b1; en = 1'b1; sync = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        wr_en3 = 1'b0; wr_ch3 = '0; wr_div3 = '0;
        for (int c = 0; c < 4; c++) div10[c] = 10;
        #2 reset = 1'b0;
        repeat (3) step();
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_clk", 32'(clk_out), 32'h0);
        chk("rst_werr", 32'(wr_err), 32'h0);
        chk("rst_tick3", 32'(tick3), 32'h0);
        reset = 1'b1;

        // defaults, all in phase; NUM_CH=3 instance rejects wr_ch=3
        for (int k = 1; k <= 25; k++) begin
            if (k == 12) begin wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 32'd5; end
            step();
            wr_en3 = 1'b0;
            chk($sformatf("def_tick k%0d", k), 32'(tick), 32'(exp_tick(k, div10)));
            chk($sformatf("def_clk k%0d", k), 32'(clk_out), 32'(exp_clk(k, div10)));
            chk($sformatf("d3_tick k%0d", k), 32'(tick3), 32'(exp_tick(k, div10) & 4'h7));
            chk($sformatf("d3_clk k%0d", k), 32'(clk_out3), 32'(exp_clk(k, div10) & 4'h7));
            chk($sformatf("d3_werr k%0d", k), 32'(wr_err3), 32'(k == 12));
        end

        // program 2/3/7/16, then align with sync
        exp_div = '{2, 3, 7, 16};
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'b1; wr_ch = 2'(c); wr_div = 32'(exp_div[c]);
            step();
            chk($sformatf("wr_werr c%0d", c), 32'(wr_err), 32'h0);
            chk($sformatf("wr_clr c%0d", c), 32'({tick[c], clk_out[c]}), 32'h0);
        end
        wr_en = 1'b0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_tick", 32'(tick), 32'h0);
        chk("sync_clk", 32'(clk_out), 32'h0);
        for (int k = 1; k <= 48; k++) begin
            if (k == 20) begin wr_en = 1'b1; wr_ch = 2'd1; wr_div = 32'd0; end
            if (k == 30) begin wr_en = 1'b1; wr_ch = 2'd2; wr_div = 32'd1; end
            if (k == 40) begin wr_en = 1'b1; wr_ch = 2'd0; wr_div = 32'd2; end
            step();
            wr_en = 1'b0;
            et = exp_tick(k, exp_div);
            ec = exp_clk(k, exp_div);
            if (k == 40) begin et[0] = 1'b0; ec[0] = 1'b0; end
            chk($sformatf("prog_tick k%0d", k), 32'(tick), 32'(et));
            chk($sformatf("prog_clk k%0d", k), 32'(clk_out), 32'(ec));
            chk($sformatf("prog_werr k%0d", k), 32'(wr_err), 32'(k == 20 || k == 30));
        end

        // write ch2=10 together with sync
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 32'd10; sync = 1'b1;
        step();
        wr_en = 1'b0; sync = 1'b0;
        exp_div[2] = 10;
        chk("wsync_tick", 32'(tick), 32'h0);
        chk("wsync_clk", 32'(clk_out), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("pre_tick k%0d", k), 32'(tick), 32'(exp_tick(k, exp_div)));
            chk($sformatf("pre_clk k%0d", k), 32'(clk_out), 32'(exp_clk(k, exp_div)));
        end
        frozen = exp_clk(4, exp_div);
        en = 1'b0;
        for (int j = 0; j < 13; j++) begin
            step();
            chk($sformatf("gate_tick j%0d", j), 32'(tick), 32'h0);
            chk($sformatf("gate_clk j%0d", j), 32'(clk_out), 32'(frozen));
        end
        en = 1'b1;
        for (int k = 5; k <= 29; k++) begin
            step();
            chk($sformatf("resume_tick k%0d", k), 32'(tick), 32'(exp_tick(k, exp_div)));
            chk($sformatf("resume_clk k%0d", k), 32'(clk_out), 32'(exp_clk(k, exp_div)));
        end
        // edge 30 is a wrap for ch0/ch1/ch2; sync must suppress the ticks
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("syncwrap_tick", 32'(tick), 32'h0);
        chk("syncwrap_clk", 32'(clk_out), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("post_tick k%0d", k), 32'(tick), 32'(exp_tick(k, exp_div)));
            chk($sformatf("post_clk k%0d", k), 32'(clk_out), 32'(exp_clk(k, exp_div)));
        end

        // ch2 now has cnt=7 and clk_out=1; reset mid-cycle
        #2 reset = 1'b0;
        #1;
        chk("midrst_tick", 32'(tick), 32'h0);
        chk("midrst_clk", 32'(clk_out), 32'h0);
        step();
        chk("midrst_hold", 32'({tick, clk_out}), 32'h0);
        reset = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            chk($sformatf("rerst_tick k%0d", k), 32'(tick), 32'(exp_tick(k, div10)));
            chk($sformatf("rerst_clk k%0d", k), 32'(clk_out), 32'(exp_clk(k, div10)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
